// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: opcode constants, FSM states, instruction classes and strobe bundle for control_unit.
package cpu_ctrl_pkg;
   localparam logic [4:0] OP_LD    = 5'b00000;
   localparam logic [4:0] OP_LDI   = 5'b00001;
   localparam logic [4:0] OP_ST    = 5'b00010;
   localparam logic [4:0] OP_ADD   = 5'b00011;
   localparam logic [4:0] OP_RLAST = 5'b01011;
   localparam logic [4:0] OP_ADDI  = 5'b01100;
   localparam logic [4:0] OP_ANDI  = 5'b01101;
   localparam logic [4:0] OP_ORI   = 5'b01110;
   localparam logic [4:0] OP_DIV   = 5'b01111;
   localparam logic [4:0] OP_MUL   = 5'b10000;
   localparam logic [4:0] OP_MFHI  = 5'b11000;
   localparam logic [4:0] OP_MFLO  = 5'b11001;
   localparam logic [4:0] OP_NOP   = 5'b11010;
   localparam logic [4:0] OP_HALT  = 5'b11011;
   localparam logic [4:0] ALU_ADD  = 5'b00011;
   localparam logic [4:0] ALU_AND  = 5'b00101;
   localparam logic [4:0] ALU_OR   = 5'b00110;

   typedef enum logic [3:0] {
      S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
   } state_t;

   typedef enum logic [3:0] {
      CL_LD, CL_LDI, CL_ST, CL_RTYPE, CL_IMM, CL_MULDIV, CL_MFHILO, CL_NOP, CL_HALT
   } class_t;

   typedef struct packed {
      logic gra, grb, grc, r_in, r_out, ba_out;
      logic pc_out, pc_in, inc_pc, ir_in, mar_in, mdr_in, mdr_out;
      logic y_in, z_in, z_low_out, z_high_out, hi_in, hi_out, lo_in, lo_out, c_out;
      logic read, write;
   } strobes_t;
endpackage

// File: rtl/instr_class_decode.sv
// instr_class_decode: combinational opcode-to-instruction-class decoder.
module instr_class_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [4:0] op,
   output class_t     cls
);
   always_comb
      cls = op == OP_LD ? CL_LD :
            op == OP_LDI ? CL_LDI :
            op == OP_ST ? CL_ST :
            (op >= OP_ADD && op <= OP_RLAST) ? CL_RTYPE :
            (op >= OP_ADDI && op <= OP_ORI) ? CL_IMM :
            (op == OP_MUL || op == OP_DIV) ? CL_MULDIV :
            (op == OP_MFHI || op == OP_MFLO) ? CL_MFHILO :
            op == OP_HALT ? CL_HALT : CL_NOP;
endmodule

// File: rtl/control_unit.sv
// control_unit: Moore fetch/decode/execute sequencer for a simple CPU datapath.
// Define CTRL_MEM_WAIT_EN to make the memory states wait for mem_done.
module control_unit
   import cpu_ctrl_pkg::*;
(
   input  logic        clock,
   input  logic        clear,
   input  logic [31:0] ir,
   input  logic        mem_done,
   output logic        Gra, Grb, Grc, Rin, Rout, BAout,
   output logic        PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout,
   output logic        Yin, Zin, Zlowout, Zhighout, HIin, HIout, LOin, LOout, Cout,
   output logic        Read, Write,
   output logic [4:0]  opcode,
   output logic        run
);
   state_t   state, state_n;
   class_t   cls, cls_q;
   logic [4:0] op_q;
   strobes_t s;
   logic     mem_ok;
   logic     unused_ir;

   assign unused_ir = ^ir[26:0];
`ifdef CTRL_MEM_WAIT_EN
   assign mem_ok = mem_done;
`else
   logic unused_mem_done;
   assign unused_mem_done = mem_done;
   assign mem_ok = 1'b1;
`endif

   instr_class_decode u_dec (.op(ir[31:27]), .cls(cls));

   // class and opcode are latched in T3 so later steps depend only on registered state
   always_ff @(posedge clock) begin
      state <= clear ? S_RESET : state_n;
      if (state == S_T3) begin
         cls_q <= cls;
         op_q  <= ir[31:27];
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         S_RESET: state_n = S_T0;
         S_T0:    state_n = S_T1;
         S_T1:    state_n = mem_ok ? S_T2 : S_T1;
         S_T2:    state_n = S_T3;
         S_T3:    state_n = cls == CL_HALT ? S_HALT :
                            (cls == CL_MFHILO || cls == CL_NOP) ? S_T0 : S_T4;
         S_T4:    state_n = S_T5;
         S_T5:    state_n = (cls_q == CL_LD || cls_q == CL_ST || cls_q == CL_MULDIV) ? S_T6 : S_T0;
         S_T6:    state_n = cls_q == CL_MULDIV ? S_T0 : (cls_q == CL_ST || mem_ok) ? S_T7 : S_T6;
         S_T7:    state_n = (cls_q == CL_LD || mem_ok) ? S_T0 : S_T7;
         S_HALT:  state_n = S_HALT;
         default: state_n = S_RESET;
      endcase
   end

   always_comb begin
      s      = '0;
      opcode = OP_NOP;
      run    = state != S_HALT;
      case (state)
         S_T0: begin
            s.pc_out = 1'b1; s.mar_in = 1'b1; s.inc_pc = 1'b1; s.z_in = 1'b1;
         end
         S_T1: begin
            s.z_low_out = 1'b1; s.pc_in = 1'b1; s.read = 1'b1; s.mdr_in = 1'b1;
         end
         S_T2: begin
            s.mdr_out = 1'b1; s.ir_in = 1'b1;
         end
         S_T3: case (cls)
            CL_LD, CL_LDI, CL_ST: begin s.grb = 1'b1; s.ba_out = 1'b1; s.y_in = 1'b1; end
            CL_RTYPE, CL_IMM:     begin s.grb = 1'b1; s.r_out = 1'b1; s.y_in = 1'b1; end
            CL_MULDIV:            begin s.gra = 1'b1; s.r_out = 1'b1; s.y_in = 1'b1; end
            CL_MFHILO: begin
               s.hi_out = ~ir[27]; s.lo_out = ir[27]; s.gra = 1'b1; s.r_in = 1'b1;
            end
            default: ;
         endcase
         S_T4: begin
            s.z_in = 1'b1;
            case (cls_q)
               CL_RTYPE:  begin s.grc = 1'b1; s.r_out = 1'b1; opcode = op_q; end
               CL_MULDIV: begin s.grb = 1'b1; s.r_out = 1'b1; opcode = op_q; end
               default: begin
                  s.c_out = 1'b1;
                  opcode = cls_q != CL_IMM ? ALU_ADD :
                           op_q == OP_ANDI ? ALU_AND : op_q == OP_ORI ? ALU_OR : ALU_ADD;
               end
            endcase
         end
         S_T5: begin
            s.z_low_out = 1'b1;
            case (cls_q)
               CL_LD, CL_ST: s.mar_in = 1'b1;
               CL_MULDIV:    s.lo_in = 1'b1;
               default:      begin s.gra = 1'b1; s.r_in = 1'b1; end
            endcase
         end
         S_T6: case (cls_q)
            CL_LD:   begin s.read = 1'b1; s.mdr_in = 1'b1; end
            CL_ST:   begin s.gra = 1'b1; s.r_out = 1'b1; s.mdr_in = 1'b1; end
            default: begin s.z_high_out = 1'b1; s.hi_in = 1'b1; end
         endcase
         S_T7: begin
            s.mdr_out = 1'b1;
            if (cls_q == CL_LD) begin
               s.gra = 1'b1; s.r_in = 1'b1;
            end else s.write = 1'b1;
         end
         default: ;
      endcase
   end

   assign {Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout,
           Yin, Zin, Zlowout, Zhighout, HIin, HIout, LOin, LOout, Cout, Read, Write} = s;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: table-driven and randomized checks of control_unit against a step-list model.
module tb_control_unit;
`ifdef CTRL_MEM_WAIT_EN
   localparam bit WAIT_EN = 1'b1;
`else
   localparam bit WAIT_EN = 1'b0;
`endif
   localparam logic [23:0] GRA = 24'h800000, GRB = 24'h400000, GRC = 24'h200000, RIN = 24'h100000;
   localparam logic [23:0] ROUT = 24'h080000, BAOUT = 24'h040000, PCOUT = 24'h020000, PCIN = 24'h010000;
   localparam logic [23:0] INCPC = 24'h008000, IRIN = 24'h004000, MARIN = 24'h002000, MDRIN = 24'h001000;
   localparam logic [23:0] MDROUT = 24'h000800, YIN = 24'h000400, ZIN = 24'h000200, ZLO = 24'h000100;
   localparam logic [23:0] ZHI = 24'h000080, HIIN = 24'h000040, HIOUT = 24'h000020, LOIN = 24'h000010;
   localparam logic [23:0] LOOUT = 24'h000008, COUT = 24'h000004, READ = 24'h000002, WRITE = 24'h000001;
   localparam logic [4:0]  NOP = 5'b11010;

   logic clock, clear, mem_done;
   logic [31:0] ir;
   logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout;
   logic Yin, Zin, Zlowout, Zhighout, HIin, HIout, LOin, LOout, Cout, Read, Write, run;
   logic [4:0] opcode;
   logic [23:0] obs;

   typedef struct { logic [23:0] v; logic [4:0] o; logic r; logic md; } step_t;
   typedef struct { logic [31:0] ir; int t1w; int mw; int lw; int lnw; logic [4:0] alu; } vec_t;
   step_t q[$];
   vec_t  tbl[$];
   int n_vec = 0, n_bad = 0;

   control_unit dut (
      .clock(clock), .clear(clear), .ir(ir), .mem_done(mem_done),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
      .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .IRin(IRin), .MARin(MARin),
      .MDRin(MDRin), .MDRout(MDRout), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
      .Zhighout(Zhighout), .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
      .Cout(Cout), .Read(Read), .Write(Write), .opcode(opcode), .run(run)
   );

   assign obs = {Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout,
                 Yin, Zin, Zlowout, Zhighout, HIin, HIout, LOin, LOout, Cout, Read, Write};

   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [29:0] act, input logic [29:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got run=%0b op=%05b strobes=%06h, want run=%0b op=%05b strobes=%06h",
                  name, act[29], act[28:24], act[23:0], exp[29], exp[28:24], exp[23:0]);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // one microstep; a wait step repeats while memory is not done (only when waits exist)
   task automatic push(input logic [23:0] v, input logic [4:0] o, input bit wt, input int w);
      if (wt && WAIT_EN) repeat (w) q.push_back('{v, o, 1'b1, 1'b0});
      q.push_back('{v, o, 1'b1, (wt && WAIT_EN) ? 1'b1 : 1'($urandom)});
   endtask

   task automatic model(input logic [4:0] op, input int t1w, input int mw);
      q.delete();
      push(PCOUT | MARIN | INCPC | ZIN, NOP, 0, 0);
      push(ZLO | PCIN | READ | MDRIN, NOP, 1, t1w);
      push(MDROUT | IRIN, NOP, 0, 0);
      if (op == 0 || op == 1 || op == 2) begin
         push(GRB | BAOUT | YIN, NOP, 0, 0);
         push(COUT | ZIN, 5'd3, 0, 0);
         if (op == 1) push(ZLO | GRA | RIN, NOP, 0, 0);
         else push(ZLO | MARIN, NOP, 0, 0);
         if (op == 0) begin
            push(READ | MDRIN, NOP, 1, mw);
            push(MDROUT | GRA | RIN, NOP, 0, 0);
         end else if (op == 2) begin
            push(GRA | ROUT | MDRIN, NOP, 0, 0);
            push(MDROUT | WRITE, NOP, 1, mw);
         end
      end else if (op >= 3 && op <= 14) begin
         push(GRB | ROUT | YIN, NOP, 0, 0);
         if (op <= 11) push(GRC | ROUT | ZIN, op, 0, 0);
         else push(COUT | ZIN, op == 12 ? 5'd3 : op == 13 ? 5'd5 : 5'd6, 0, 0);
         push(ZLO | GRA | RIN, NOP, 0, 0);
      end else if (op == 15 || op == 16) begin
         push(GRA | ROUT | YIN, NOP, 0, 0);
         push(GRB | ROUT | ZIN, op, 0, 0);
         push(ZLO | LOIN, NOP, 0, 0);
         push(ZHI | HIIN, NOP, 0, 0);
      end else if (op == 24) push(HIOUT | GRA | RIN, NOP, 0, 0);
      else if (op == 25) push(LOOUT | GRA | RIN, NOP, 0, 0);
      else if (op == 27) begin
         push(24'h0, NOP, 0, 0);
         repeat (20) q.push_back('{24'h0, NOP, 1'b0, 1'($urandom)});
      end else push(24'h0, NOP, 0, 0);
   endtask

   // starts at a negedge with the DUT in T0; stop=1 ends when T0 comes round again
   task automatic apply(input string name, input bit stop, output int lat, output logic [4:0] seen);
      lat = 0;
      seen = NOP;
      while (lat < 64) begin
         if (stop && lat > 0 && PCout) break;
         if (!stop && lat >= q.size()) break;
         if (lat >= q.size()) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s overrun: still busy after %0d cycles, want T0 after %0d", name, lat, q.size());
            break;
         end
         check($sformatf("%s cycle %0d", name, lat), {run, opcode, obs}, {q[lat].r, q[lat].o, q[lat].v});
         if (opcode !== NOP) seen = opcode;
         mem_done = q[lat].md;
         @(negedge clock);
         lat++;
      end
   endtask

   initial begin
      int lat, k;
      logic [4:0] seen, op;
      clock = 0; clear = 1; ir = 0; mem_done = 0;
      tbl.push_back('{32'h0880_0005,          0, 0,  6, 6, 5'd3});
      tbl.push_back('{{5'd3,  27'h123_4567},  3, 0,  9, 6, 5'd3});
      tbl.push_back('{{5'd0,  27'h000_0010},  0, 2, 10, 8, 5'd3});
      tbl.push_back('{{5'd16, 27'h5A5_A5A5},  0, 0,  7, 7, 5'd16});
      tbl.push_back('{{5'd2,  27'h0F0_0F00},  1, 1, 10, 8, 5'd3});
      tbl.push_back('{{5'd15, 27'h111_1111},  0, 0,  7, 7, 5'd15});
      tbl.push_back('{{5'd4,  27'h222_2222},  0, 0,  6, 6, 5'd4});
      tbl.push_back('{{5'd11, 27'h333_3333},  2, 0,  8, 6, 5'd11});
      tbl.push_back('{{5'd12, 27'h444_4444},  0, 0,  6, 6, 5'd3});
      tbl.push_back('{{5'd13, 27'h555_5555},  0, 0,  6, 6, 5'd5});
      tbl.push_back('{{5'd14, 27'h666_6666},  0, 0,  6, 6, 5'd6});
      tbl.push_back('{{5'd24, 27'h777_7777},  0, 0,  4, 4, NOP});
      tbl.push_back('{{5'd25, 27'h000_0001},  0, 0,  4, 4, NOP});
      tbl.push_back('{{5'd26, 27'h000_0002},  0, 0,  4, 4, NOP});
      tbl.push_back('{{5'd17, 27'h000_0003},  0, 0,  4, 4, NOP});
      tbl.push_back('{{5'd31, 27'h000_0004},  1, 0,  5, 4, NOP});
      tbl.push_back('{{5'd0,  27'h000_0005},  1, 3, 12, 8, 5'd3});
      tbl.push_back('{{5'd1,  27'h000_0006},  0, 3,  6, 6, 5'd3});

      repeat (2) @(negedge clock);
      check("reset state", {run, opcode, obs}, {1'b1, NOP, 24'h0});
      clear = 0;
      @(negedge clock);

      for (int i = 0; i < tbl.size(); i++) begin
         ir = tbl[i].ir;
         model(ir[31:27], tbl[i].t1w, tbl[i].mw);
         apply($sformatf("vec%0d", i), 1'b1, lat, seen);
         check_int($sformatf("vec%0d latency", i), lat, WAIT_EN ? tbl[i].lw : tbl[i].lnw);
         check_int($sformatf("vec%0d alu opcode", i), int'(seen), int'(tbl[i].alu));
      end

      for (int i = 0; i < 40; i++) begin
         op = 5'($urandom_range(0, 31));
         if (op == 5'd27) op = NOP;
         ir = {op, 27'($urandom)};
         model(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         apply($sformatf("rnd%0d op=%05b", i, op), 1'b1, lat, seen);
         check_int($sformatf("rnd%0d length", i), lat, q.size());
      end

      ir = {5'd27, 27'h0};
      model(5'd27, 0, 0);
      apply("halt", 1'b0, lat, seen);
      clear = 1;
      mem_done = 0;
      @(negedge clock);
      check("halt cleared to reset", {run, opcode, obs}, {1'b1, NOP, 24'h0});
      clear = 0;
      @(negedge clock);
      check("T0 after halt", {run, opcode, obs}, {1'b1, NOP, PCOUT | MARIN | INCPC | ZIN});

      ir = {5'd2, 27'h0};
      mem_done = 1;
      k = 0;
      while (!Write && k < 20) begin
         @(negedge clock);
         k++;
      end
      check_int("st reaches write step", int'(Write), 1);
      mem_done = 0;
      clear = 1;
      @(negedge clock);
      check("clear in st write wait", {run, opcode, obs}, {1'b1, NOP, 24'h0});
      clear = 0;
      @(negedge clock);
      check("T0 after st clear", {run, opcode, obs}, {1'b1, NOP, PCOUT | MARIN | INCPC | ZIN});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port clock  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port clear  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port ir  input  32  IR contents; opcode = ir[31:27], sampled only in state T3.
REQ-004 SHALL have port mem_done  input  1  memory read/write complete strobe.
REQ-005 SHALL have ports Gra, Grb, Grc, Rin, Rout, BAout  output  1 each  register-select and register-file strobes.
REQ-006 SHALL have ports PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout  output  1 each  PC, IR, MAR and MDR strobes.
REQ-007 SHALL have ports Yin, Zin, Zlowout, Zhighout, HIin, HIout, LOin, LOout, Cout  output  1 each  ALU-side strobes.
REQ-008 SHALL have ports Read, Write  output  1 each  memory commands.
REQ-009 SHALL have port opcode  output  5  ALU operation select.
REQ-010 SHALL have port run  output  1  high unless halted.

Function
REQ-011 SHALL be a Moore FSM: every output is a decode of the present-state register only, with one state per clock.
REQ-012 SHALL hold every strobe at 0 and opcode at 5'b11010 (nop) in any state that does not name them.
REQ-013 SHALL run fetch T0: PCout, MARin, IncPC, Zin.
REQ-014 SHALL run fetch T1: Zlowout, PCin, Read, MDRin, and stay in T1 until mem_done=1.
REQ-015 SHALL run fetch T2: MDRout, IRin.
REQ-016 SHALL decode ir[31:27] in T3 and branch by class.
REQ-017 SHALL execute ld (00000) as T3 Grb BAout Yin; T4 Cout Zin opcode=00011; T5 Zlowout MARin; T6 Read MDRin, waiting for mem_done; T7 MDRout Gra Rin; then T0.
REQ-018 SHALL execute ldi (00001) as T3 Grb BAout Yin; T4 Cout Zin opcode=00011; T5 Zlowout Gra Rin; then T0.
REQ-019 SHALL execute st (00010) as T3 to T5 per ld; T6 Gra Rout MDRin with Read=0; T7 MDRout Write, waiting for mem_done; then T0.
REQ-020 SHALL execute R-type (00011 to 01011) as T3 Grb Rout Yin; T4 Grc Rout Zin opcode=ir[31:27]; T5 Zlowout Gra Rin; then T0.
REQ-021 SHALL execute immediate ops (01100 to 01110) as T3 Grb Rout Yin; T4 Cout Zin, with opcode = 00011, 00101 or 00110 respectively; T5 Zlowout Gra Rin.
REQ-022 SHALL execute mul/div (10000, 01111) as T3 Gra Rout Yin; T4 Grb Rout Zin opcode=ir[31:27]; T5 Zlowout LOin; T6 Zhighout HIin; then T0.
REQ-023 SHALL handle mfhi (11000) and mflo (11001) as T3 HIout (or LOout) Gra Rin; then T0.
REQ-024 SHALL treat nop (11010) and every unlisted opcode as T3 with no strobes, then T0.
REQ-025 SHALL enter HALTED on halt (11011) at T3, with run=0 and no strobes, until clear.
REQ-026 SHALL treat mem_done as ignored outside the two memory-wait states; mem_done already high on entry SHALL give a one-cycle wait state.
REQ-027 SHALL give these latencies with zero wait: R-type 6 cycles, ldi 6, ld 8, st 8, nop 4.

Reset
REQ-028 SHALL, when clear=1 at a rising edge in any state (including memory-wait or HALTED), enter RESET next cycle, with all strobes 0, opcode 11010 and run=1.
REQ-029 SHALL leave RESET for T0 on the first edge with clear=0.

Configuration
REQ-030 SHALL, when macro CTRL_MEM_WAIT_EN is defined, implement the mem_done waits in REQ-014, REQ-017 and REQ-019.
REQ-031 SHALL, when CTRL_MEM_WAIT_EN is undefined, leave every memory state after exactly one cycle, with mem_done unused.

Structure
REQ-032 SHALL place opcode constants (5-bit) and the state enumeration in shared package cpu_ctrl_pkg.
REQ-033 SHALL contain one sub-module, instr_class_decode, a combinational opcode-to-class decoder (LD, LDI, ST, RTYPE, IMM, MULDIV, MFHILO, NOP, HALT).

Verification
REQ-034 SHALL cover: clear 2 cycles, ir=ldi (0x0880_0005), mem_done=1 -> T3 Grb/BAout/Yin, T4 opcode=00011 with Cout, T5 Gra/Rin, T0 next.
REQ-035 SHALL cover: add, ir[31:27]=00011, mem_done delayed 3 cycles in T1 -> Read/MDRin held 3 cycles; R-type strobe sequence follows.
REQ-036 SHALL cover: ld with mem_done delayed 2 cycles in T6 -> Read held 2 cycles, then T7 MDRout/Gra/Rin; total 10 cycles.
REQ-037 SHALL cover: mul (10000) -> T5 LOin with Zlowout, T6 HIin with Zhighout.
REQ-038 SHALL cover: halt (11011) -> run=0 persists 20 cycles; clear -> RESET, then T0 with run=1.
REQ-039 SHALL cover: clear asserted in st T7 wait -> next cycle RESET, Write=0.
